fxp8s_mul_seq: RTL and testbench

- Iterative shift-add multiplier for the FXP8S sign-magnitude fixed-point format: bit 7 is the sign, bits 6:0 are the magnitude, and the LSB weight is 2^-3.
- It is the counterpart of the combinational FXP8S divider. The datapath pairs it with the divider for scale and unscale operations.
- One multiply takes 7 clock cycles.
- Operands arrive through a valid/ready handshake; results leave through a second valid/ready handshake.
- The magnitude result saturates, and an overflow flag is raised when it does.

---
 rtl/fxp8s_pkg.sv | 17 +
 rtl/fxp8s_mul_seq_if.sv | 26 ++
 rtl/fxp8s_mag_sat.sv | 21 ++
 rtl/fxp8s_mul_seq.sv | 109 ++++++++++
 tb/tb_fxp8s_mul_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fxp8s_pkg.sv
// Shared FXP8S sign-magnitude format constants and sequencer state encoding.
// Used by both the iterative multiplier and the divider.
package fxp8s_pkg;

    localparam int          FXP8S_WIDTH   = 8;
    localparam int          FXP8S_SIGN    = 7;
    localparam int          FXP8S_MAG_W   = 7;
    localparam int          FXP8S_FRAC_W  = 3;
    localparam logic [6:0]  FXP8S_MAG_MAX = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fxp8s_state_e;

endpackage

// File: rtl/fxp8s_mul_seq_if.sv
// Operand and result valid/ready handshakes of the FXP8S sequential multiplier.
// The producer/consumer side uses master; the multiplier uses slave.
interface fxp8s_mul_seq_if;
    import fxp8s_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [FXP8S_WIDTH-1:0] in_a;
    logic [FXP8S_WIDTH-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [FXP8S_WIDTH-1:0] out_p;
    logic                   out_ovf;
    logic                   busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, out_ovf, busy
    );

endinterface

// File: rtl/fxp8s_mag_sat.sv
// Rescales a double-width raw magnitude product by the fractional shift,
// truncating toward zero, and clamps or wraps it to MAG_W bits.
module fxp8s_mag_sat
    import fxp8s_pkg::*;
#(
    parameter int MAG_W    = FXP8S_MAG_W,
    parameter int FRAC_W   = FXP8S_FRAC_W,
    parameter int SATURATE = 1
) (
    input  logic [2*MAG_W-1:0] raw,
    output logic [MAG_W-1:0]   mag,
    output logic               ovf
);

    logic [2*MAG_W-1:0] scaled;

    assign scaled = raw >> FRAC_W;
    assign ovf    = |scaled[2*MAG_W-1:MAG_W];
    assign mag    = (ovf && (SATURATE != 0)) ? '1 : scaled[MAG_W-1:0];

endmodule

// File: rtl/fxp8s_mul_seq.sv
// Iterative shift-add FXP8S multiplier: one multiplier bit per cycle, fixed
// MAG_W-cycle latency, registered saturated result held until consumed.
module fxp8s_mul_seq
    import fxp8s_pkg::*;
#(
    parameter int MAG_W    = FXP8S_MAG_W,
    parameter int FRAC_W   = FXP8S_FRAC_W,
    parameter int SATURATE = 1
) (
    input  logic            clk,
    input  logic            rst,
    fxp8s_mul_seq_if.slave  bus
);

    localparam int ACC_W = 2 * MAG_W;
    localparam int CNT_W = $clog2(MAG_W);

    fxp8s_state_e       state_q, state_d;
    logic [MAG_W-1:0]   a_mag_q, b_mag_q;
    logic               sign_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MAG_W:0]     p_q;
    logic               ovf_q;

    logic               in_ready_c, busy_c;
    logic               accept, iter_last;
    logic [ACC_W-1:0]   addend, acc_sum;
    logic [MAG_W-1:0]   sat_mag;
    logic               sat_ovf;

    assign accept    = bus.in_valid && in_ready_c;
    assign iter_last = (cnt_q == CNT_W'(MAG_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch.
        state_d    = state_q;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = BUSY;
            end
            BUSY: begin
                busy_c = 1'b1;
                if (iter_last) state_d = DONE;
            end
            DONE: begin
                // Result handoff and the next accept may share one edge.
                in_ready_c = bus.out_ready;
                if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign addend  = b_mag_q[cnt_q] ? (ACC_W'(a_mag_q) << cnt_q) : '0;
    assign acc_sum = acc_q + addend;

    fxp8s_mag_sat #(
        .MAG_W    (MAG_W),
        .FRAC_W   (FRAC_W),
        .SATURATE (SATURATE)
    ) u_mag_sat (
        .raw (acc_sum),
        .mag (sat_mag),
        .ovf (sat_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mag_q <= '0;
            b_mag_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_mag_q <= bus.in_a[MAG_W-1:0];
            b_mag_q <= bus.in_b[MAG_W-1:0];
            sign_q  <= bus.in_a[FXP8S_SIGN] ^ bus.in_b[FXP8S_SIGN];
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == BUSY) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + 1'b1;
            if (iter_last) begin
                // A zero magnitude never carries a sign.
                p_q   <= {sign_q & (|sat_mag), sat_mag};
                ovf_q <= sat_ovf;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_p     = p_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_fxp8s_mul_seq.sv
// Self-checking bench for fxp8s_mul_seq: vector table, backpressure,
// back-to-back, reset abort, wrap mode and a randomized scoreboard run.
module tb_fxp8s_mul_seq;
    import fxp8s_pkg::*;

    localparam int N_RAND = 400;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_p;
        logic       exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fxp8s_mul_seq_if bus ();
    fxp8s_mul_seq_if bus_w ();

    fxp8s_mul_seq #(.SATURATE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fxp8s_mul_seq #(.SATURATE(0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input bit sat);
        logic [13:0] raw;
        logic [13:0] scaled;
        logic [6:0]  mag;
        logic        ovf;
        raw    = 14'(a[6:0]) * 14'(b[6:0]);
        scaled = raw >> 3;
        ovf    = scaled > 14'd127;
        mag    = (ovf && sat) ? 7'h7F : scaled[6:0];
        return {ovf, (a[7] ^ b[7]) && (mag != 7'd0), mag};
    endfunction

    // Called at the negedge after the accept edge; counts edges until out_valid.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.out_valid) fail("result_timeout");
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] p, output logic ovf, output int lat);
        int w;
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            fail("accept_timeout");
            bus.in_valid = 1'b0;
            p = 'x; ovf = 'x; lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(lat);
        p = bus.out_p;
        ovf = bus.out_ovf;
    endtask

    initial begin
        vec_t       vecs[12];
        logic [7:0] p;
        logic       ovf;
        int         lat, w;
        bit         stable, seen;

        vecs[0]  = '{8'h10, 8'h1C, 8'h38, 1'b0};
        vecs[1]  = '{8'h90, 8'h1C, 8'hB8, 1'b0};
        vecs[2]  = '{8'h81, 8'h01, 8'h00, 1'b0};
        vecs[3]  = '{8'h40, 8'h20, 8'h7F, 1'b1};
        vecs[4]  = '{8'hC0, 8'h20, 8'hFF, 1'b1};
        vecs[5]  = '{8'h08, 8'h08, 8'h08, 1'b0};
        vecs[6]  = '{8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[7]  = '{8'h7F, 8'h08, 8'h7F, 1'b0};
        vecs[8]  = '{8'h7F, 8'h09, 8'h7F, 1'b1};
        vecs[9]  = '{8'h8C, 8'h9C, 8'h2A, 1'b0};
        vecs[10] = '{8'h0F, 8'h83, 8'h85, 1'b0};
        vecs[11] = '{8'h11, 8'h11, 8'h24, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        bus_w.in_valid = 1'b0; bus_w.in_a = '0; bus_w.in_b = '0; bus_w.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_p", bus.out_p, 8'h00);
        check("rst_out_ovf", bus.out_ovf, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, p, ovf, lat);
            check($sformatf("vec%0d_p", i), p, vecs[i].exp_p);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
            check($sformatf("vec%0d_latency", i), lat, 7);
        end

        // Wrap-mode overflow on the second instance.
        @(negedge clk);
        bus_w.in_a = 8'h40; bus_w.in_b = 8'h20; bus_w.in_valid = 1'b1;
        #1 check("wrap_in_ready", bus_w.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus_w.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("wrap_out_valid", bus_w.out_valid, 1'b1);
        check("wrap_out_p", bus_w.out_p, 8'h00);
        check("wrap_out_ovf", bus_w.out_ovf, 1'b1);

        // Backpressure, then a same-cycle handoff and accept.
        @(negedge clk);
        bus.in_a = 8'h10; bus.in_b = 8'h1C; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_out_p", bus.out_p, 8'h38);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_p !== 8'h38 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1'b1);
        bus.out_ready = 1'b1;
        bus.in_a = 8'h08; bus.in_b = 8'h08; bus.in_valid = 1'b1;
        #1 check("b2b_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        check("b2b_out_valid_low", bus.out_valid, 1'b0);
        wait_result(lat);
        check("b2b_latency", lat, 7);
        check("b2b_out_p", bus.out_p, 8'h08);

        // Reset three cycles into an operation drops it.
        @(negedge clk);
        bus.in_a = 8'h10; bus.in_b = 8'h1C; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort_in_ready", bus.in_ready, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_stale", seen, 1'b0);

        // Randomized run: producer and consumer with independent gaps.
        fork
            begin : producer
                logic [7:0] ra, rb;
                int         pw;
                for (int n = 0; n < N_RAND; n++) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    bus.in_a = ra; bus.in_b = rb; bus.in_valid = 1'b1;
                    #2;
                    pw = 0;
                    while (!bus.in_ready && pw < 60) begin
                        @(negedge clk);
                        #2;
                        pw++;
                    end
                    if (!bus.in_ready) begin
                        fail("rand_accept_timeout");
                        break;
                    end
                    exp_q.push_back(model(ra, rb, 1'b1));
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin : consumer
                int         got, cyc;
                logic [8:0] e;
                got = 0; cyc = 0;
                while (got < N_RAND && cyc < 20000) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    #2;
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            fail("rand_unexpected_result");
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("rand%0d_p", got), bus.out_p, e[7:0]);
                            check($sformatf("rand%0d_ovf", got), bus.out_ovf, e[8]);
                        end
                        got++;
                    end
                    cyc++;
                end
                if (got < N_RAND) fail("rand_drain_timeout");
            end
        join

        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rand_no_duplicate", seen, 1'b0);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
